// File: rtl/alu_control_32_bit_pkg.sv
// Shared widths and encodings for the MIPS ALU-control decoder.
// Covers the ALUOp classes, the R-type funct values and the ALU operation codes.
package alu_control_pkg;

    localparam int OP_W    = 2;
    localparam int FUNCT_W = 6;
    localparam int CODE_W  = 4;

    typedef logic [OP_W-1:0]    alu_op_t;
    typedef logic [FUNCT_W-1:0] funct_t;
    typedef logic [CODE_W-1:0]  alu_code_t;

    localparam alu_op_t ALUOP_MEM   = 2'b00;
    localparam alu_op_t ALUOP_BR    = 2'b01;
    localparam alu_op_t ALUOP_RTYPE = 2'b10;

    localparam funct_t F_ADD  = 6'b100000;
    localparam funct_t F_ADDU = 6'b100001;
    localparam funct_t F_SUB  = 6'b100010;
    localparam funct_t F_SUBU = 6'b100011;
    localparam funct_t F_AND  = 6'b100100;
    localparam funct_t F_OR   = 6'b100101;
    localparam funct_t F_XOR  = 6'b100110;
    localparam funct_t F_NOR  = 6'b100111;
    localparam funct_t F_SLT  = 6'b101010;
    localparam funct_t F_SLTU = 6'b101011;

    localparam alu_code_t ALU_AND     = 4'b0000;
    localparam alu_code_t ALU_OR      = 4'b0001;
    localparam alu_code_t ALU_ADD     = 4'b0010;
    localparam alu_code_t ALU_XOR     = 4'b0011;
    localparam alu_code_t ALU_SUB     = 4'b0110;
    localparam alu_code_t ALU_SLT     = 4'b0111;
    localparam alu_code_t ALU_NOR     = 4'b1100;
    localparam alu_code_t ALU_ILLEGAL = 4'b1111;

endpackage

// File: rtl/alu_control_32_bit_if.sv
// Request/response bundle between main control, the ALU-control stage and the ALU.
// The master side drives the request; the slave side returns the registered code.
interface alu_control_32_bit_if;
    import alu_control_pkg::*;

    logic      in_valid;
    alu_op_t   aluOp;
    funct_t    fuct_field;
    alu_code_t aluCode;
    logic      out_valid;
    logic      illegal;

    modport master (
        output in_valid, aluOp, fuct_field,
        input  aluCode, out_valid, illegal
    );

    modport slave (
        input  in_valid, aluOp, fuct_field,
        output aluCode, out_valid, illegal
    );

endinterface

// File: rtl/alu_control_32_bit_decode.sv
// Purely combinational ALUOp/funct to ALU-code decode.
// Anything outside the supported set maps to ALU_ILLEGAL with the illegal flag raised.
module alu_control_decode
    import alu_control_pkg::*;
(
    input  alu_op_t   aluOp_i,
    input  funct_t    fuct_field_i,
    output alu_code_t code_o,
    output logic      illegal_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch can be inferred.
        code_o    = ALU_ILLEGAL;
        illegal_o = 1'b1;
        case (aluOp_i)
            ALUOP_MEM: begin
                code_o    = ALU_ADD;
                illegal_o = 1'b0;
            end
            ALUOP_BR: begin
                code_o    = ALU_SUB;
                illegal_o = 1'b0;
            end
            ALUOP_RTYPE: begin
                illegal_o = 1'b0;
                case (fuct_field_i)
                    F_ADD, F_ADDU: code_o = ALU_ADD;
                    F_SUB, F_SUBU: code_o = ALU_SUB;
                    F_AND:         code_o = ALU_AND;
                    F_OR:          code_o = ALU_OR;
                    F_XOR:         code_o = ALU_XOR;
                    F_NOR:         code_o = ALU_NOR;
                    F_SLT, F_SLTU: code_o = ALU_SLT;
                    default: begin
                        code_o    = ALU_ILLEGAL;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            default: begin
                code_o    = ALU_ILLEGAL;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control_32_bit.sv
// Registered ALU-control stage: decodes a valid ALUOp/funct pair into the ALU code
// one cycle later; code and illegal flag hold while no valid input arrives.
module alu_control_32_bit
    import alu_control_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    alu_control_32_bit_if.slave   bus
);

    alu_code_t dec_code;
    logic      dec_illegal;

    alu_code_t code_d, code_q;
    logic      illegal_d, illegal_q;
    logic      valid_d, valid_q;

    alu_control_decode u_decode (
        .aluOp_i      (bus.aluOp),
        .fuct_field_i (bus.fuct_field),
        .code_o       (dec_code),
        .illegal_o    (dec_illegal)
    );

    always_comb begin
        code_d    = code_q;
        illegal_d = illegal_q;
        valid_d   = bus.in_valid;
        if (bus.in_valid) begin
            code_d    = dec_code;
            illegal_d = dec_illegal;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q    <= ALU_AND;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            code_q    <= code_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.aluCode   = code_q;
    assign bus.illegal   = illegal_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_alu_control_32_bit.sv
// Self-checking bench: directed cycle table followed by random traffic
// compared against a lookup-based reference model.
module tb_alu_control_32_bit;
    import alu_control_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    alu_control_32_bit_if bus ();

    alu_control_32_bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] exp_code;
        logic       exp_valid;
        logic       exp_illegal;
    } vec_t;

    vec_t vecs[$];

    // Reference: R-type funct lookup table plus registered state
    logic [3:0] rtype_map [logic [5:0]];
    logic [3:0] m_code;
    logic       m_valid;
    logic       m_illegal;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic r, input logic v, input logic [1:0] op, input logic [5:0] fn);
        @(negedge clk);
        rst            = r;
        bus.in_valid   = v;
        bus.aluOp      = op;
        bus.fuct_field = fn;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [1:0] op, input logic [5:0] fn);
        if (r) begin
            m_code = 4'b0000; m_valid = 1'b0; m_illegal = 1'b0;
        end else begin
            m_valid = v;
            if (v) begin
                if (op == 2'd0) begin
                    m_code = 4'b0010; m_illegal = 1'b0;
                end else if (op == 2'd1) begin
                    m_code = 4'b0110; m_illegal = 1'b0;
                end else if (op == 2'd2 && rtype_map.exists(fn)) begin
                    m_code = rtype_map[fn]; m_illegal = 1'b0;
                end else begin
                    m_code = 4'b1111; m_illegal = 1'b1;
                end
            end
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op, input logic [5:0] fn,
                                input logic [3:0] c, input logic ov, input logic il);
        vec_t t;
        t.rst = r; t.vld = v; t.op = op; t.fn = fn;
        t.exp_code = c; t.exp_valid = ov; t.exp_illegal = il;
        return t;
    endfunction

    initial begin
        logic [5:0] legal_fn [10];

        rtype_map[6'b100000] = 4'b0010;  // add
        rtype_map[6'b100001] = 4'b0010;  // addu
        rtype_map[6'b100010] = 4'b0110;  // sub
        rtype_map[6'b100011] = 4'b0110;  // subu
        rtype_map[6'b100100] = 4'b0000;  // and
        rtype_map[6'b100101] = 4'b0001;  // or
        rtype_map[6'b100110] = 4'b0011;  // xor
        rtype_map[6'b100111] = 4'b1100;  // nor
        rtype_map[6'b101010] = 4'b0111;  // slt
        rtype_map[6'b101011] = 4'b0111;  // sltu
        legal_fn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                     6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};

        // Reset held two cycles with a valid request present, then released
        vecs.push_back(mk(1, 1, 2'b10, 6'b100010, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100010, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 6'b100010, 4'b0110, 1, 0));
        // Non-R-type classes ignore funct
        vecs.push_back(mk(0, 1, 2'b00, 6'b000000, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 2'b01, 6'b000000, 4'b0110, 1, 0));
        vecs.push_back(mk(0, 1, 2'b00, 6'b101010, 4'b0010, 1, 0));
        // Back-to-back R-type sweep
        vecs.push_back(mk(0, 1, 2'b10, 6'b100000, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 6'b100010, 4'b0110, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 6'b100100, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 6'b100101, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 6'b101010, 4'b0111, 1, 0));
        // Illegal combinations, then recovery
        vecs.push_back(mk(0, 1, 2'b11, 6'b101010, 4'b1111, 1, 1));
        vecs.push_back(mk(0, 1, 2'b10, 6'b111111, 4'b1111, 1, 1));
        vecs.push_back(mk(0, 1, 2'b10, 6'b100101, 4'b0001, 1, 0));
        // Hold on in_valid=0
        vecs.push_back(mk(0, 1, 2'b10, 6'b100100, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 0, 2'b01, 6'b000000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 6'b111111, 4'b1111, 1, 1));
        vecs.push_back(mk(0, 0, 2'b00, 6'b100000, 4'b1111, 0, 1));
        // Reset wins over a simultaneous valid illegal request
        vecs.push_back(mk(1, 1, 2'b11, 6'b000000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 0, 2'b11, 6'b000000, 4'b0000, 0, 0));

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.aluOp      = 2'b00;
        bus.fuct_field = 6'b000000;

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].rst, vecs[i].vld, vecs[i].op, vecs[i].fn);
            check($sformatf("vec%0d.aluCode", i),   bus.aluCode,          vecs[i].exp_code);
            check($sformatf("vec%0d.out_valid", i), {3'b0, bus.out_valid}, {3'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d.illegal", i),   {3'b0, bus.illegal},   {3'b0, vecs[i].exp_illegal});
        end

        // Model state after the last table row (reset then idle)
        m_code = 4'b0000; m_valid = 1'b0; m_illegal = 1'b0;

        for (int k = 0; k < 400; k++) begin
            logic       r, v;
            logic [1:0] op;
            logic [5:0] fn;
            r  = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 1) == 0) ? legal_fn[$urandom_range(0, 9)] : 6'($urandom);
            drive_cycle(r, v, op, fn);
            model_step(r, v, op, fn);
            check($sformatf("rnd%0d.aluCode", k),   bus.aluCode,          m_code);
            check($sformatf("rnd%0d.out_valid", k), {3'b0, bus.out_valid}, {3'b0, m_valid});
            check($sformatf("rnd%0d.illegal", k),   {3'b0, bus.illegal},   {3'b0, m_illegal});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
